// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the instruction ROM: Start/Ack run handshake,
// LUT-based branch redirection, halt detection and a saturating run-cycle counter.
module fetch_sequencer #(
    parameter int A      = 10,
    parameter int LUT_IW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [A-1:0]      StartAddr,
    input  logic              Halt,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [LUT_IW-1:0] BranchIdx,
    input  logic              LutWe,
    input  logic [LUT_IW-1:0] LutWIdx,
    input  logic [A-1:0]      LutWData,
    output logic [A-1:0]      InstAddress,
    output logic              Running,
    output logic              Ack,
    output logic [CNT_W-1:0]  CycleCount
);

    // Start/Ack handshake: Start is a level sampled in IDLE or DONE; the run begins the
    // following cycle (Running=1, Ack=0). Ack stays high in DONE until the next Start is seen.
    // Start is ignored while Running.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LUT_DEPTH = 2 ** LUT_IW;

    state_t       state;
    logic [A-1:0] lut [LUT_DEPTH];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            InstAddress <= '0;
            Running     <= 1'b0;
            Ack         <= 1'b0;
            CycleCount  <= '0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else begin
            // Branch reads below see the pre-write entry, so a same-cycle write lands next cycle.
            if (LutWe) begin
                lut[LutWIdx] <= LutWData;
            end

            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state       <= RUN;
                        InstAddress <= StartAddr;
                        CycleCount  <= '0;
                        Running     <= 1'b1;
                        Ack         <= 1'b0;
                    end
                end

                RUN: begin
                    if (Halt) begin
                        state   <= DONE;
                        Running <= 1'b0;
                        Ack     <= 1'b1;
                    end else begin
                        if (!Stall) begin
                            if (BranchTaken) begin
                                InstAddress <= lut[BranchIdx];
                            end else begin
                                InstAddress <= InstAddress + A'(1);
                            end
                        end
                        if (CycleCount != {CNT_W{1'b1}}) begin
                            CycleCount <= CycleCount + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                    Ack     <= 1'b0;
                end
            endcase
        end
    end

endmodule
